text_pixel_pipe: RTL and testbench
==================================

Name: text_pixel_pipe

Overview:
- Downstream consumer of the character/row counter. Takes the current frame-buffer character index, glyph row and column-within-glyph (cur_char, glyph_row, char_row) plus the sync/valid sideband.
- Fetches the character code and attribute from the frame-buffer RAM, looks up the glyph row in the font ROM, and selects the pixel bit.
- Applies attribute colours, blink and cursor overlay, then drives 4-bit RGB to the DAC pins with sync delayed to match.

Parameters:
- FB_AW, 12, frame-buffer address width (2400 character cells used).
- CURSOR_TOP, 14, first glyph row (0-15) of the underline cursor.
- BLINK_BIT, 4, frame-counter bit used as the character blink phase.
- CURSOR_BIT, 3, frame-counter bit used as the cursor flash phase.

Ports:
- CLK  in  1  pixel clock (25.175 MHz).
- RST_N  in  1  reset; asynchronous assert, active-low.
- cur_char  in  12  cell index from the counter.
- glyph_row  in  4  glyph scanline 0-15.
- char_row  in  3  pixel column within glyph 0-7; 0 is leftmost.
- valid_in  in  1  active-video pixel.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- fb_addr  out  FB_AW  frame-buffer read address = cur_char (combinational).
- fb_data  in  16  synchronous RAM data, valid 1 cycle after fb_addr. Bits [7:0] are the char code, [15:8] the attribute.
- font_addr  out  12  {char_code, glyph_row_d1} (combinational).
- font_data  in  8  synchronous ROM data, valid 1 cycle after font_addr. Bit 7 is the leftmost pixel.
- cursor_pos  in  12  cell index of the cursor.
- cursor_en  in  1  cursor visible.
- red, green, blue  out  4 each  pixel colour.
- hsync_out, vsync_out  out  1 each  sync aligned to RGB.
- valid_out  out  1  valid aligned to RGB.

Behaviour:
- Reset (RST_N low, asynchronous):
  - red/green/blue = 0, valid_out = 0, hsync_out = vsync_out = 1.
  - All pipeline delay registers cleared: valid to 0, syncs to 1, others to 0.
  - Frame counter = 0 and vsync edge-detect register = 1.
  - Reset release takes effect on the next CLK edge. Deasserting reset mid-frame needs no resync: outputs follow inputs after 3 cycles.
- Pipeline, with inputs sampled at cycle t:
  - Cycle t: fb_addr = cur_char.
  - Cycle t+1: fb_data is present. font_addr = {fb_data[7:0], glyph_row_d1}. The attribute, char_row and sideband are carried in d1 registers.
  - Cycle t+2: font_data is present. The attribute is carried in a d2 register alongside char_row_d2, glyph_row_d2, cur_char_d2 and the sideband.
  - Cycle t+3: the registered outputs are visible. Fixed latency is 3 cycles for RGB, valid_out, hsync_out and vsync_out, with no bubbles or stalls.
- Pixel bit = font_data[7 - char_row_d2].
- Attribute fields:
  - fg = attr[3:0].
  - bg = {1'b0, attr[6:4]}.
  - blink = attr[7].
- Palette, index {I,R,G,B}: each channel = colour bit ? (I ? 15 : 10) : (I ? 5 : 0). There is no brown exception.
- Frame counter: 5-bit, increments on each falling edge of vsync_in, detected against the previous sampled value. It wraps from 31 to 0.
- Colour selection at stage 2, in priority order:
  1. valid_d2 = 0 → RGB = 0.
  2. Cursor hit → use fg. Hit = cursor_en and cur_char_d2 == cursor_pos and glyph_row_d2 >= CURSOR_TOP and frame_cnt[CURSOR_BIT] = 1.
  3. Blink suppress → use bg. Suppress = blink and frame_cnt[BLINK_BIT] = 1.
  4. Otherwise: pixel bit ? fg : bg.
- cursor_pos and cursor_en are sampled at stage 2 without delay. Software changes take effect within a pixel, and tearing is acceptable.
- Simultaneous events:
  - A vsync falling edge on the same cycle as a pixel uses the old frame_cnt value for that pixel.
  - Cursor and blink on the same cell: the cursor takes priority.
- cur_char values ≥ 2400 are passed unchanged to fb_addr; no clamping.

Test Plan:
- Reset: hold RST_N low mid-stream with valid_in = 1 → RGB = 0, valid_out = 0, hsync_out = vsync_out = 1 immediately (asynchronous), before any CLK edge.
- Latency: drive valid_in = 1, cur_char = 5 at cycle 0 with a RAM model holding 0x1F41 and a ROM model holding 0x80 for char 0x41, row 0, char_row = 0 → fb_addr = 5 at cycle 0, font_addr = 0x410 at cycle 1, RGB = (15,15,15) at cycle 3. With char_row = 1 → RGB = (0,0,10), blue bg.
- Sync alignment: pulse hsync_in low for cycles 10-105 → hsync_out low for cycles 13-108. valid_in edges are delayed by exactly 3 cycles.
- Blink: attribute 0x9F, font bit set, generate 16 vsync falling edges → RGB switches from fg (15,15,15) to bg (0,0,10). After 32 edges the counter wraps to 0 and fg is restored.
- Cursor: cursor_en = 1, cursor_pos = 80, frame_cnt = 8, cur_char = 80, glyph_row = 15, font bit 0, attribute 0x07 → RGB = (10,10,10). With glyph_row = 13 → RGB = 0. With cursor_en = 0 and glyph_row = 15 → RGB = 0.
- Blanking: valid_in = 0 with font bit set → RGB = 0 three cycles later, regardless of attribute or cursor.

Source files
------------

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel pipeline: frame-buffer fetch, font lookup, attribute colouring,
// blink and cursor overlay, with sync and valid delayed to stay aligned with RGB.
module text_pixel_pipe #(
    parameter int FB_AW      = 12,
    parameter int CURSOR_TOP = 14,
    parameter int BLINK_BIT  = 4,
    parameter int CURSOR_BIT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [11:0]      cur_char,
    input  logic [3:0]       glyph_row,
    input  logic [2:0]       char_row,
    input  logic             valid_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [15:0]      fb_data,
    output logic [11:0]      font_addr,
    input  logic [7:0]       font_data,
    input  logic [11:0]      cursor_pos,
    input  logic             cursor_en,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             valid_out
);

    logic [11:0] cur_char_p1, cur_char_p2;
    logic [3:0]  glyph_row_p1, glyph_row_p2;
    logic [2:0]  char_row_p1, char_row_p2;
    logic        vld_p1, vld_p2;
    logic        hsync_p1, hsync_p2;
    logic        vsync_p1, vsync_p2;
    logic [7:0]  attr_p2;
    logic [4:0]  frame_cnt;
    logic        vsync_prev;
    logic        pix_bit;
    logic        cursor_hit;
    logic        blink_off;
    logic [11:0] rgb_p2;

    function automatic logic [3:0] chan_level(input logic on, input logic intense);
        return on ? (intense ? 4'd15 : 4'd10) : (intense ? 4'd5 : 4'd0);
    endfunction

    // Palette index is {I,R,G,B}; result packed as {red, green, blue}.
    function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
        return {chan_level(idx[2], idx[3]), chan_level(idx[1], idx[3]),
                chan_level(idx[0], idx[3])};
    endfunction

    // Stage 0: frame-buffer address straight from the counter
    assign fb_addr = FB_AW'(cur_char);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_char_p1  <= '0;
            glyph_row_p1 <= '0;
            char_row_p1  <= '0;
            vld_p1       <= 1'b0;
            hsync_p1     <= 1'b1;
            vsync_p1     <= 1'b1;
        end else begin
            cur_char_p1  <= cur_char;
            glyph_row_p1 <= glyph_row;
            char_row_p1  <= char_row;
            vld_p1       <= valid_in;
            hsync_p1     <= hsync_in;
            vsync_p1     <= vsync_in;
        end
    end

    // Stage 1: RAM data present, font address formed from the char code
    assign font_addr = {fb_data[7:0], glyph_row_p1};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_char_p2  <= '0;
            glyph_row_p2 <= '0;
            char_row_p2  <= '0;
            attr_p2      <= '0;
            vld_p2       <= 1'b0;
            hsync_p2     <= 1'b1;
            vsync_p2     <= 1'b1;
        end else begin
            cur_char_p2  <= cur_char_p1;
            glyph_row_p2 <= glyph_row_p1;
            char_row_p2  <= char_row_p1;
            attr_p2      <= fb_data[15:8];
            vld_p2       <= vld_p1;
            hsync_p2     <= hsync_p1;
            vsync_p2     <= vsync_p1;
        end
    end

    // The counter bumps after the edge cycle, so a pixel coinciding with the edge sees the old phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt  <= '0;
            vsync_prev <= 1'b1;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_prev && !vsync_in)
                frame_cnt <= frame_cnt + 5'd1;
        end
    end

    // Stage 2: font data present; pick the colour
    always_comb begin
        pix_bit    = font_data[3'd7 - char_row_p2];
        cursor_hit = cursor_en && (cur_char_p2 == cursor_pos) &&
                     (glyph_row_p2 >= 4'(CURSOR_TOP)) && frame_cnt[CURSOR_BIT];
        blink_off  = attr_p2[7] && frame_cnt[BLINK_BIT];
        rgb_p2     = '0;
        if (!vld_p2)
            rgb_p2 = '0;
        else if (cursor_hit)
            rgb_p2 = palette_rgb(attr_p2[3:0]);
        else if (blink_off)
            rgb_p2 = palette_rgb({1'b0, attr_p2[6:4]});
        else
            rgb_p2 = palette_rgb(pix_bit ? attr_p2[3:0] : {1'b0, attr_p2[6:4]});
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            valid_out <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            red       <= rgb_p2[11:8];
            green     <= rgb_p2[7:4];
            blue      <= rgb_p2[3:0];
            valid_out <= vld_p2;
            hsync_out <= hsync_p2;
            vsync_out <= vsync_p2;
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Scoreboard bench for text_pixel_pipe: random and directed pixels checked against
// a cell/attribute level model of the text display.
module tb_text_pixel_pipe;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [11:0] cur_char;
    logic [3:0]  glyph_row;
    logic [2:0]  char_row;
    logic        valid_in, hsync_in, vsync_in;
    logic [11:0] fb_addr;
    logic [15:0] fb_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] cursor_pos;
    logic        cursor_en;
    logic [3:0]  red, green, blue;
    logic        hsync_out, vsync_out, valid_out;

    text_pixel_pipe dut (
        .CLK(CLK), .RST_N(RST_N), .cur_char(cur_char), .glyph_row(glyph_row),
        .char_row(char_row), .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .fb_addr(fb_addr), .fb_data(fb_data), .font_addr(font_addr), .font_data(font_data),
        .cursor_pos(cursor_pos), .cursor_en(cursor_en), .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .valid_out(valid_out)
    );

    always #20 CLK = ~CLK;

    logic [15:0] ram [4096];
    logic [7:0]  rom [4096];

    always @(posedge CLK) begin
        fb_data   <= ram[fb_addr];
        font_data <= rom[font_addr];
    end

    typedef struct {
        logic [11:0] cc;
        logic [3:0]  gr;
        logic [2:0]  cr;
        logic        v, hs, vs;
    } pix_t;

    pix_t        pend[$];
    logic [14:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          fc = 0;
    logic        prev_vs = 1'b1;
    logic [11:0] want_pos = '0;
    logic        want_en = 1'b0;
    logic        rnd_vs = 1'b1;
    logic [14:0] mon_exp;
    logic [11:0] got_rgb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] level(input logic on, input logic bright);
        int l;
        l = (on ? 10 : 0) + (bright ? 5 : 0);
        return 4'(l);
    endfunction

    // What the display should show for one pixel, given the current frame phase and cursor.
    function automatic logic [14:0] model_out(input pix_t p);
        logic [7:0] code, attr, glyph;
        logic [3:0] idx;
        logic       lit;
        if (!p.v) return {1'b0, p.hs, p.vs, 12'h000};
        code  = ram[p.cc][7:0];
        attr  = ram[p.cc][15:8];
        glyph = rom[{code, p.gr}];
        lit   = glyph[7 - int'(p.cr)];
        if (want_en && p.cc == want_pos && p.gr >= 14 && ((fc / 8) % 2) == 1)
            idx = attr[3:0];
        else if (attr[7] && ((fc / 16) % 2) == 1)
            idx = {1'b0, attr[6:4]};
        else
            idx = lit ? attr[3:0] : {1'b0, attr[6:4]};
        return {1'b1, p.hs, p.vs, level(idx[2], idx[3]), level(idx[1], idx[3]),
                level(idx[0], idx[3])};
    endfunction

    // Drive one pixel; expectations are formed two pixels later, when the cursor is sampled.
    task automatic apply(input logic [11:0] cc, input logic [3:0] gr, input logic [2:0] cr,
                         input logic v, input logic hs, input logic vs);
        pix_t p;
        cur_char = cc; glyph_row = gr; char_row = cr;
        valid_in = v; hsync_in = hs; vsync_in = vs;
        cursor_pos = want_pos; cursor_en = want_en;
        p.cc = cc; p.gr = gr; p.cr = cr; p.v = v; p.hs = hs; p.vs = vs;
        pend.push_back(p);
        if (pend.size() == 3) exp_q.push_back(model_out(pend.pop_front()));
        if (prev_vs && !vs) fc = (fc + 1) % 32;
        prev_vs = vs;
    endtask

    task automatic step(input logic [11:0] cc, input logic [3:0] gr, input logic [2:0] cr,
                        input logic v, input logic hs, input logic vs);
        apply(cc, gr, cr, v, hs, vs);
        @(negedge CLK);
    endtask

    task automatic probe(input logic [11:0] cc, input logic [3:0] gr, input logic [2:0] cr,
                         input logic v, output logic [11:0] rgb);
        apply(cc, gr, cr, v, 1'b1, 1'b1);
        @(negedge CLK);
        apply(12'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        apply(12'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        @(posedge CLK);
        #2;
        rgb = {red, green, blue};
        @(negedge CLK);
    endtask

    task automatic vs_edges(input int n);
        for (int i = 0; i < n; i++) begin
            step(12'd6, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1);
            step(12'd6, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        end
        step(12'd6, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic random_run(input int n);
        logic [11:0] cc;
        logic [3:0]  gr;
        for (int i = 0; i < n; i++) begin
            if ($urandom % 16 == 0) begin
                want_pos = 12'($urandom);
                want_en  = 1'($urandom);
            end
            cc = ($urandom % 4 == 0) ? want_pos : 12'($urandom);
            gr = ($urandom % 2 == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom);
            if ($urandom % 8 == 0) rnd_vs = ~rnd_vs;
            step(cc, gr, 3'($urandom), ($urandom % 8) != 0, ($urandom % 16) != 0, rnd_vs);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {valid_out, hsync_out, vsync_out, red, green, blue}, {3'b011, 12'h000});
    endtask

    always @(posedge CLK) begin
        #1;
        if (RST_N && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("pixel", {valid_out, hsync_out, vsync_out, red, green, blue}, mon_exp);
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        cur_char = '0; glyph_row = '0; char_row = '0;
        valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        cursor_pos = '0; cursor_en = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[5] = 16'h1F41; rom[12'h410] = 8'h80;
        ram[6] = 16'h9F41;
        ram[80] = 16'h0742; rom[12'h42F] = 8'h00; rom[12'h42D] = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_initial");
        RST_N = 1'b1;

        // Latency and address formation
        apply(12'd5, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        #1 chk("fb_addr", fb_addr, 12'd5);
        @(negedge CLK);
        apply(12'd5, 4'd0, 3'd1, 1'b1, 1'b1, 1'b1);
        #1 chk("font_addr", font_addr, 12'h410);
        @(negedge CLK);
        apply(12'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        @(posedge CLK);
        #2 chk("latency_fg", {red, green, blue}, 12'hFFF);
        @(negedge CLK);
        apply(12'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        @(posedge CLK);
        #2 chk("latency_bg", {red, green, blue}, 12'h00A);
        @(negedge CLK);

        // hsync low for pixels 10..105 inside a valid window
        for (int c = 0; c < 120; c++)
            step(12'($urandom), 4'($urandom), 3'($urandom), (c >= 5 && c < 110),
                 !(c >= 10 && c <= 105), 1'b1);

        random_run(1500);

        // Asynchronous reset mid-stream with valid_in high
        step(12'($urandom), 4'($urandom), 3'($urandom), 1'b1, 1'b1, 1'b1);
        #3 RST_N = 1'b0;
        pend.delete(); exp_q.delete(); fc = 0; prev_vs = 1'b1;
        #1 check_reset_outputs("reset_async");
        @(posedge CLK);
        #1 check_reset_outputs("reset_held");
        @(negedge CLK);
        RST_N = 1'b1;

        random_run(500);

        // Blink phase and counter wrap
        want_en = 1'b0;
        vs_edges((32 - fc) % 32);
        probe(12'd6, 4'd0, 3'd0, 1'b1, got_rgb);
        chk("blink_fc0", got_rgb, 12'hFFF);
        vs_edges(16);
        probe(12'd6, 4'd0, 3'd0, 1'b1, got_rgb);
        chk("blink_fc16", got_rgb, 12'h00A);
        vs_edges(16);
        probe(12'd6, 4'd0, 3'd0, 1'b1, got_rgb);
        chk("blink_wrap", got_rgb, 12'hFFF);

        // Cursor overlay at frame count 8
        vs_edges(8);
        want_pos = 12'd80; want_en = 1'b1;
        probe(12'd80, 4'd15, 3'd0, 1'b1, got_rgb);
        chk("cursor_hit", got_rgb, 12'hAAA);
        probe(12'd80, 4'd13, 3'd0, 1'b1, got_rgb);
        chk("cursor_row13", got_rgb, 12'h000);
        want_en = 1'b0;
        probe(12'd80, 4'd15, 3'd0, 1'b1, got_rgb);
        chk("cursor_off", got_rgb, 12'h000);

        // Blanking overrides font, attribute and cursor
        want_en = 1'b1;
        probe(12'd80, 4'd15, 3'd0, 1'b0, got_rgb);
        chk("blank_cursor", got_rgb, 12'h000);
        probe(12'd5, 4'd0, 3'd0, 1'b0, got_rgb);
        chk("blank_fg", got_rgb, 12'h000);

        random_run(300);
        repeat (4) step(12'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
